mvm_host_driver: RTL and testbench

- Initiator-side controller for the mvm_16_1_8_1 accelerator.
- Accepts matrix/vector words from an upstream valid/ready stream and issues the loadMatrix/loadVector/start command sequence with gapless data bursts.
- Waits for done, captures the k result words into a local buffer, then drains them downstream over a valid/ready stream with backpressure.
- Sits between the system datapath and one MVM instance.

---
 rtl/mvm_drv_pkg.sv | 25 ++
 rtl/mvm_result_buf.sv | 25 ++
 rtl/mvm_host_driver.sv | 186 ++++++++++++++++++
 tb/tb_mvm_host_driver.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_drv_pkg.sv
// Shared types and default sizing for the MVM host driver.
package mvm_drv_pkg;

    localparam int K_DEF        = 16;
    localparam int B_DEF        = 8;
    localparam int DOUT_LAT_DEF = 1;
    localparam int TIMEOUT_DEF  = 1024;

    localparam int MAT_WORDS = K_DEF * K_DEF;
    localparam int CNT_W     = $clog2(K_DEF * K_DEF + 1);
    localparam int TO_W      = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [3:0] {
        IDLE,
        LDM_CMD,
        LDM_DATA,
        LDV_CMD,
        LDV_DATA,
        START,
        WAIT,
        CAPTURE,
        DRAIN
    } state_t;

endpackage

// File: rtl/mvm_result_buf.sv
// K-entry result register file: one write port filled during capture,
// one combinational read port used while draining.
module mvm_result_buf #(
    parameter int K  = 16,
    parameter int W  = 16,
    parameter int AW = $clog2(K)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [K];

    // Store one captured result word
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_host_driver.sv
// Host-side sequencer for one MVM accelerator: streams matrix/vector words
// in gapless bursts, waits for done, captures K results, drains them out.
//
// state    | meaning
// IDLE     | ready for a job
// LDM_CMD  | loadMatrix command cycle
// LDM_DATA | K*K matrix words, one per cycle
// LDV_CMD  | loadVector command cycle
// LDV_DATA | K vector words, one per cycle
// START    | start pulse, timeout counter cleared
// WAIT     | waiting for done or timeout
// CAPTURE  | sampling y[0..K-1] after DOUT_LAT
// DRAIN    | handing results downstream
module mvm_host_driver
    import mvm_drv_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int B        = B_DEF,
    parameter int DOUT_LAT = DOUT_LAT_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           job_go,
    input  logic           job_reuse_m,
    output logic           job_ready,
    output logic           job_done,
    output logic           err_underrun,
    output logic           err_timeout,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B-1:0]   in_data,
    output logic           mvm_loadMatrix,
    output logic           mvm_loadVector,
    output logic           mvm_start,
    output logic [B-1:0]   mvm_data_in,
    input  logic           mvm_done,
    input  logic [2*B-1:0] mvm_data_out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*B-1:0] out_data
);

    localparam int MW = K * K;
    localparam int CW = $clog2(K * K + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(DOUT_LAT + 1);
    localparam int IW = $clog2(K);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   to_cnt;
    logic [LW-1:0]   lat;
    logic            buf_we;
    logic [2*B-1:0]  buf_rdata;

    wire mat_last = (cnt == CW'(MW - 1));
    wire vec_last = (cnt == CW'(K - 1));
    wire to_last  = (to_cnt == TW'(TIMEOUT - 1));
    wire lat_hit  = (lat == LW'(DOUT_LAT));

    // Next-state and output decode from the state register
    always_comb begin
        state_nx       = state;
        job_ready      = 1'b0;
        job_done       = 1'b0;
        in_ready       = 1'b0;
        mvm_loadMatrix = 1'b0;
        mvm_loadVector = 1'b0;
        mvm_start      = 1'b0;
        mvm_data_in    = '0;
        out_valid      = 1'b0;
        buf_we         = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_go) state_nx = job_reuse_m ? LDV_CMD : LDM_CMD;
            end
            LDM_CMD: begin
                mvm_loadMatrix = 1'b1;
                state_nx       = LDM_DATA;
            end
            LDM_DATA: begin
                in_ready    = 1'b1;
                mvm_data_in = in_valid ? in_data : '0;
                if (mat_last) state_nx = LDV_CMD;
            end
            LDV_CMD: begin
                mvm_loadVector = 1'b1;
                state_nx       = LDV_DATA;
            end
            LDV_DATA: begin
                in_ready    = 1'b1;
                mvm_data_in = in_valid ? in_data : '0;
                if (vec_last) state_nx = START;
            end
            START: begin
                mvm_start = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                if (mvm_done) begin
                    state_nx = CAPTURE;
                end else if (to_last) begin
                    job_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            CAPTURE: begin
                if (lat_hit) begin
                    buf_we = 1'b1;
                    if (vec_last) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && vec_last) begin
                    job_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, counters and sticky error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            to_cnt       <= '0;
            lat          <= '0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (job_go) begin
                        err_underrun <= 1'b0;
                        err_timeout  <= 1'b0;
                        cnt          <= '0;
                    end
                end
                LDM_DATA: begin
                    if (!in_valid) err_underrun <= 1'b1;
                    cnt <= mat_last ? '0 : cnt + CW'(1);
                end
                LDV_DATA: begin
                    if (!in_valid) err_underrun <= 1'b1;
                    cnt <= vec_last ? '0 : cnt + CW'(1);
                end
                START: to_cnt <= '0;
                WAIT: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (mvm_done) begin
                        lat <= LW'(1);
                        cnt <= '0;
                    end else if (to_last) begin
                        err_timeout <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!lat_hit) lat <= lat + LW'(1);
                    else          cnt <= vec_last ? '0 : cnt + CW'(1);
                end
                DRAIN: begin
                    if (out_ready) cnt <= vec_last ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    mvm_result_buf #(.K(K), .W(2 * B)) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (cnt[IW-1:0]),
        .wdata (mvm_data_out),
        .raddr (cnt[IW-1:0]),
        .rdata (buf_rdata)
    );

    assign out_data = (state == DRAIN) ? buf_rdata : '0;

endmodule

// File: tb/tb_mvm_host_driver.sv
// Self-checking bench for mvm_host_driver with an MVM responder model.
module tb_mvm_host_driver;

    localparam int K  = 16;
    localparam int B  = 8;
    localparam int TO = 64;
    localparam int MW = K * K;

    logic clk = 1'b0;
    logic reset;
    logic job_go, job_reuse_m, job_ready, job_done, err_underrun, err_timeout;
    logic in_valid, in_ready;
    logic [B-1:0] in_data;
    logic mvm_loadMatrix, mvm_loadVector, mvm_start, mvm_done;
    logic [B-1:0] mvm_data_in;
    logic [2*B-1:0] mvm_data_out;
    logic out_valid, out_ready;
    logic [2*B-1:0] out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mvm_host_driver #(.K(K), .B(B), .DOUT_LAT(1), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .job_go(job_go), .job_reuse_m(job_reuse_m), .job_ready(job_ready),
        .job_done(job_done), .err_underrun(err_underrun), .err_timeout(err_timeout),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mvm_loadMatrix(mvm_loadMatrix), .mvm_loadVector(mvm_loadVector),
        .mvm_start(mvm_start), .mvm_data_in(mvm_data_in),
        .mvm_done(mvm_done), .mvm_data_out(mvm_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // ---------------- upstream feeder ----------------
    logic [B-1:0] feed_q[$];
    int feed_slot = 0;
    int drop_slot = -1;

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (feed_q.size() > 0) begin
                in_data  = feed_q[0];
                in_valid = (feed_slot != drop_slot);
            end else begin
                in_data  = '0;
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (reset && in_ready) begin
                if (feed_q.size() > 0) void'(feed_q.pop_front());
                feed_slot++;
            end
        end
    end

    // ---------------- MVM responder model ----------------
    int bfm_a[MW];
    int bfm_x[K];
    int bfm_y[K];
    bit bfm_no_done = 1'b0;
    int bfm_lat = 3;
    int n_ldm, n_ldv, n_start, n_inrdy;
    int ldm_cyc, ldv_cyc, start_cyc, ldm_gap, ldv_gap;

    initial begin
        int mode;
        int idx;
        mode = 0;
        idx = 0;
        mvm_done = 1'b0;
        mvm_data_out = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mode = 0;
            end else begin
                if (in_ready) n_inrdy++;
                if (mvm_loadMatrix) begin
                    n_ldm++; ldm_cyc = cyc; mode = 1; idx = 0;
                end else if (mvm_loadVector) begin
                    n_ldv++; ldm_gap = cyc - ldm_cyc; ldv_cyc = cyc; mode = 2; idx = 0;
                end else if (mvm_start) begin
                    n_start++; ldv_gap = cyc - ldv_cyc; start_cyc = cyc; mode = 0;
                    if (!bfm_no_done) begin
                        for (int i = 0; i < K; i++) begin
                            bfm_y[i] = 0;
                            for (int j = 0; j < K; j++) bfm_y[i] += bfm_a[i*K+j] * bfm_x[j];
                        end
                        repeat (bfm_lat) begin
                            @(posedge clk); #1;
                            mvm_data_out = 16'($urandom);
                        end
                        mvm_done = 1'b1;
                        @(posedge clk); #1;
                        mvm_done = 1'b0;
                        for (int i = 0; i < K; i++) begin
                            mvm_data_out = 16'(bfm_y[i]);
                            @(posedge clk); #1;
                        end
                        mvm_data_out = 16'($urandom);
                    end
                end else if (mode == 1) begin
                    bfm_a[idx] = int'($signed(mvm_data_in));
                    idx++;
                    if (idx == MW) mode = 0;
                end else if (mode == 2) begin
                    bfm_x[idx] = int'($signed(mvm_data_in));
                    idx++;
                    if (idx == K) mode = 0;
                end
            end
        end
    end

    // ---------------- job stimulus / reference ----------------
    int ta[MW];
    int tx[K];
    logic [2*B-1:0] ty[K];
    logic [2*B-1:0] got[$];
    int n_done, stall_bad, done_cyc;
    bit done_accept, timed_out, post_ready, post_to, post_un;

    task automatic push_job(input bit with_m);
        if (with_m) for (int i = 0; i < MW; i++) feed_q.push_back(8'(ta[i]));
        for (int i = 0; i < K; i++) feed_q.push_back(8'(tx[i]));
    endtask

    // y = A*x in wrapping 2B-bit arithmetic
    task automatic calc_exp();
        for (int i = 0; i < K; i++) begin
            int s;
            s = 0;
            for (int j = 0; j < K; j++) s += ta[i*K+j] * tx[j];
            ty[i] = 16'(s);
        end
    endtask

    task automatic rand_data(input bit with_m);
        if (with_m) for (int i = 0; i < MW; i++) ta[i] = int'($signed(8'($urandom)));
        for (int i = 0; i < K; i++) tx[i] = int'($signed(8'($urandom)));
    endtask

    task automatic run_job(input bit reuse, input int rmode);
        bit prev_stall;
        logic [2*B-1:0] prev_data;
        bit acc;
        got.delete();
        n_done = 0; stall_bad = 0; done_accept = 0; timed_out = 0; done_cyc = 0;
        n_ldm = 0; n_ldv = 0; n_start = 0; n_inrdy = 0;
        ldm_gap = -1; ldv_gap = -1;
        feed_slot = 0;
        prev_stall = 0; prev_data = '0;
        bfm_lat = $urandom_range(1, 8);
        push_job(!reuse);
        @(posedge clk); #1;
        job_go = 1'b1; job_reuse_m = reuse;
        @(posedge clk); #1;
        job_go = 1'b0; job_reuse_m = 1'b0;
        for (int c = 0; c < 3000 && n_done == 0; c++) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom);
            endcase
            @(negedge clk);
            if (prev_stall && out_data !== prev_data) stall_bad++;
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            acc = out_valid && out_ready;
            if (acc) got.push_back(out_data);
            if (job_done) begin
                n_done++; done_accept = acc; done_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        if (n_done == 0) timed_out = 1;
        out_ready = 1'b0;
        @(negedge clk);
        post_ready = job_ready; post_to = err_timeout; post_un = err_underrun;
        if (job_done) n_done++;
    endtask

    task automatic check_results(input string name);
        checks++;
        if (timed_out) begin
            failures++; $display("FAIL %s_timeout: job_done not seen within budget", name);
        end
        checks++;
        if (got.size() != K) begin
            failures++; $display("FAIL %s_count: got %0d words, expected %0d", name, got.size(), K);
        end else begin
            for (int i = 0; i < K; i++) begin
                checks++;
                if (got[i] !== ty[i]) begin
                    failures++;
                    $display("FAIL %s_y%0d: got %h expected %h", name, i, got[i], ty[i]);
                end
            end
        end
        checks++;
        if (n_done != 1 || !done_accept) begin
            failures++;
            $display("FAIL %s_done: pulses %0d on_accept %0d, expected 1 1", name, n_done, done_accept);
        end
        checks++;
        if (!post_ready) begin
            failures++; $display("FAIL %s_ready_after: got 0 expected 1", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic check_idle_outputs(input string name);
        logic [10:0] obs;
        obs = {job_ready, job_done, err_underrun, err_timeout, in_ready, mvm_loadMatrix,
               mvm_loadVector, mvm_start, out_valid, |mvm_data_in, |out_data};
        checks++;
        if (obs !== 11'b100_0000_0000) begin
            failures++; $display("FAIL %s: outputs %b expected %b", name, obs, 11'b10000000000);
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset_state");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_release");
    endtask

    task automatic test_identity();
        for (int i = 0; i < MW; i++) ta[i] = (i / K == i % K) ? 1 : 0;
        for (int i = 0; i < K; i++) tx[i] = i + 1;
        calc_exp();
        run_job(1'b0, 0);
        check_results("identity");
        checks++;
        if (n_ldm != 1 || n_ldv != 1 || n_start != 1) begin
            failures++; $display("FAIL identity_cmds: ldm %0d ldv %0d start %0d expected 1 1 1", n_ldm, n_ldv, n_start);
        end
        checks++;
        if (ldm_gap != MW + 1 || ldv_gap != K + 1) begin
            failures++; $display("FAIL identity_gaps: got %0d %0d expected %0d %0d", ldm_gap, ldv_gap, MW + 1, K + 1);
        end
        checks++;
        if (n_inrdy != MW + K) begin
            failures++; $display("FAIL identity_in_ready: got %0d cycles expected %0d", n_inrdy, MW + K);
        end
        checks++;
        if (post_un || post_to) begin
            failures++; $display("FAIL identity_errs: got %0d %0d expected 0 0", post_un, post_to);
        end
    endtask

    task automatic test_reuse();
        for (int i = 0; i < MW; i++) ta[i] = 2;
        for (int i = 0; i < K; i++) tx[i] = 3;
        calc_exp();
        checks++;
        if (ty[0] !== 16'h0060) begin
            failures++; $display("FAIL model_96: got %h expected 0060", ty[0]);
        end
        run_job(1'b0, 0);
        check_results("all2x3");
        for (int i = 0; i < K; i++) tx[i] = 1;
        calc_exp();
        run_job(1'b1, 0);
        check_results("reuse");
        checks++;
        if (n_ldm != 0 || n_inrdy != K || ldv_gap != K + 1) begin
            failures++; $display("FAIL reuse_cmds: ldm %0d in_ready %0d gap %0d expected 0 %0d %0d", n_ldm, n_inrdy, ldv_gap, K, K + 1);
        end
    endtask

    task automatic test_underrun();
        int a4;
        rand_data(1'b1);
        ta[5] = (ta[5] == 0) ? 7 : ta[5];
        a4 = ta[4];
        drop_slot = 5;
        push_job(1'b1);
        feed_q.delete();
        ta[5] = ta[5];
        begin
            int keep5;
            keep5 = ta[5];
            ta[5] = 0;
            calc_exp();
            ta[5] = keep5;
        end
        run_job(1'b0, 0);
        drop_slot = -1;
        check_results("underrun");
        checks++;
        if (!post_un || post_to) begin
            failures++; $display("FAIL underrun_flag: got %0d %0d expected 1 0", post_un, post_to);
        end
        checks++;
        if (bfm_a[5] != 0 || bfm_a[4] != a4) begin
            failures++; $display("FAIL underrun_data: a5 %0d a4 %0d expected 0 %0d", bfm_a[5], bfm_a[4], a4);
        end
        checks++;
        if (ldm_gap != MW + 1 || n_inrdy != MW + K) begin
            failures++; $display("FAIL underrun_burst: gap %0d in_ready %0d expected %0d %0d", ldm_gap, n_inrdy, MW + 1, MW + K);
        end
    endtask

    task automatic test_backpressure();
        rand_data(1'b1);
        calc_exp();
        run_job(1'b0, 1);
        check_results("bp");
        checks++;
        if (stall_bad != 0) begin
            failures++; $display("FAIL bp_stable: %0d changes while stalled, expected 0", stall_bad);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            bit r;
            r = (n > 0) && 1'($urandom);
            rand_data(!r);
            calc_exp();
            run_job(r, 2);
            check_results("rand");
            checks++;
            if (stall_bad != 0 || post_un) begin
                failures++; $display("FAIL rand_proto: stall %0d underrun %0d expected 0 0", stall_bad, post_un);
            end
        end
    endtask

    task automatic test_timeout();
        rand_data(1'b1);
        bfm_no_done = 1'b1;
        run_job(1'b0, 0);
        bfm_no_done = 1'b0;
        checks++;
        if (n_done != 1 || done_cyc - start_cyc != TO) begin
            failures++; $display("FAIL timeout_cycles: pulses %0d wait %0d expected 1 %0d", n_done, done_cyc - start_cyc, TO);
        end
        checks++;
        if (!post_to || !post_ready || got.size() != 0) begin
            failures++; $display("FAIL timeout_flag: err %0d ready %0d words %0d expected 1 1 0", post_to, post_ready, got.size());
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int b;
        rand_data(1'b1);
        feed_slot = 0;
        push_job(1'b1);
        @(posedge clk); #1; job_go = 1'b1;
        @(posedge clk); #1; job_go = 1'b0;
        seen = 0;
        for (b = 0; b < 1000 && seen < 101; b++) begin
            @(negedge clk);
            if (in_ready) seen++;
        end
        checks++;
        if (seen < 101) begin
            failures++; $display("FAIL mid_reach: saw %0d burst words expected 101", seen);
        end
        #2 reset = 1'b0;
        #1 check_idle_outputs("mid_async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        feed_q.delete();
        feed_slot = 0;
        rand_data(1'b1);
        calc_exp();
        run_job(1'b0, 2);
        check_results("after_reset");
        checks++;
        if (post_un || post_to || n_ldm != 1) begin
            failures++; $display("FAIL after_reset_state: un %0d to %0d ldm %0d expected 0 0 1", post_un, post_to, n_ldm);
        end
    endtask

    initial begin
        reset = 1'b0;
        job_go = 1'b0;
        job_reuse_m = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_identity();
        test_reuse();
        test_underrun();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
